// File: rtl/mmio_debug_port.sv
// Memory-mapped debug responder for the CPU data bus.
// Decodes a 1 MiB I/O window and provides:
//   - a console TX FIFO that drains to a host sink over valid/ready,
//   - a free-running 64-bit cycle counter with a coherent high-word snapshot,
//   - a sticky EXIT register that raises halt and captures an exit code.
module mmio_debug_port #(
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CNT_W      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] exit_code
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] OFF_TXDATA = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_CYC_LO = 3'd2;
    localparam logic [2:0] OFF_CYC_HI = 3'd3;
    localparam logic [2:0] OFF_EXIT   = 3'd4;

    logic             sel;
    logic [2:0]       off;
    logic             wr_en;
    logic             rd_en;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       count8;
    logic             overflow;
    logic             full;
    logic             empty;

    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             ovf_clr;

    logic [63:0]      cyc_cnt;
    logic [31:0]      cyc_hi_snap;

    // Address bits outside the decoded fields and the upper byte enables
    // carry no meaning for this block.
    logic             unused_bits;
    assign unused_bits = ^{addr[19:5], addr[1:0], be[3:1]};

    assign sel   = (addr[31:20] == BASE_ADDR[31:20]);
    assign off   = addr[4:2];
    assign wr_en = we && sel;
    assign rd_en = re && sel;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign count8   = 8'(count);
    assign tx_valid = !empty;
    // Head byte comes straight from storage; forced to zero when empty so
    // stale entries never show on the stream.
    assign tx_data  = empty ? 8'h00 : mem[rd_ptr];

    // A full FIFO can still take a byte when the head leaves in the same cycle.
    assign pop      = tx_valid && tx_ready;
    assign push_req = wr_en && (off == OFF_TXDATA) && be[0];
    assign push_ok  = push_req && (!full || pop);
    assign ovf_clr  = wr_en && (off == OFF_STATUS) && wdata[2];

    // Load data mux; reads have no side effects here (snapshot is handled below).
    always_comb begin
        rdata = 32'h0;
        if (rd_en) begin
            case (off)
                OFF_STATUS: rdata = {16'h0, count8, 5'b0, overflow, empty, full};
                OFF_CYC_LO: rdata = cyc_cnt[31:0];
                OFF_CYC_HI: rdata = cyc_hi_snap;
                default:    rdata = 32'h0;
            endcase
        end
    end

    // FIFO entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Free-running cycle counter; wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= 64'h0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'h1;
        end
    end

    // Reading the low word freezes the matching high word so a LO-then-HI
    // pair is coherent even if the low word carries in between.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_hi_snap <= 32'h0;
        end else if (rd_en && (off == OFF_CYC_LO)) begin
            cyc_hi_snap <= cyc_cnt[63:32];
        end
    end

    // EXIT register: only the first write counts; halt holds until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt      <= 1'b0;
            exit_code <= 32'h0;
        end else if (wr_en && (off == OFF_EXIT) && !halt) begin
            halt      <= 1'b1;
            exit_code <= wdata;
        end
    end

endmodule
